// File: rtl/baud_pkg.sv
// Shared constants, divisor type and reset-divisor helper for the UART baud generator.
package baud_pkg;

    localparam int unsigned OVSAMP_DEFAULT    = 8;
    localparam int unsigned DIV_WIDTH_DEFAULT = 16;
    localparam int unsigned FRAC_WIDTH        = 4;

    typedef logic [DIV_WIDTH_DEFAULT-1:0] div_t;

    // Clock cycles per oversample tick, rounded down; a zero rate yields 0 (treated as 1).
    function automatic longint unsigned bddiv(
        input longint unsigned clk_rate,
        input longint unsigned baud_rate,
        input longint unsigned ovsamp = OVSAMP_DEFAULT
    );
        if ((baud_rate == 0) || (ovsamp == 0)) begin
            return 0;
        end
        return clk_rate / (baud_rate * ovsamp);
    endfunction

endpackage

// File: rtl/uart_baud_prescaler.sv
// Divisor register, pending load and down-counter producing one pulse per oversample period.
// With UART_BAUD_FRAC_EN defined, a 4-bit fractional accumulator stretches periods on carry.
module uart_baud_prescaler
    import baud_pkg::*;
#(
    parameter int unsigned          DIV_WIDTH = DIV_WIDTH_DEFAULT,
    parameter logic [DIV_WIDTH-1:0] RST_DIV   = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 sync_i,
    input  logic                 div_load_i,
    input  logic [DIV_WIDTH-1:0] div_i,
`ifdef UART_BAUD_FRAC_EN
    input  logic [FRAC_WIDTH-1:0] frac_i,
`endif
    output logic [DIV_WIDTH-1:0] div_o,
    output logic                 tick_c
);

    localparam logic [DIV_WIDTH-1:0] RST_CNT =
        (RST_DIV == '0) ? '0 : RST_DIV - DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] pend_div_q;
    logic                 pend_vld_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] nxt_div;
    logic [DIV_WIDTH-1:0] nxt_base;
    logic                 reload;
    logic [DIV_WIDTH-1:0] stretch;

`ifdef UART_BAUD_FRAC_EN
    localparam int unsigned ACC_W = FRAC_WIDTH + 1;

    logic [FRAC_WIDTH-1:0] frac_q;
    logic [FRAC_WIDTH-1:0] pend_frac_q;
    logic [FRAC_WIDTH-1:0] acc_q;
    logic [FRAC_WIDTH-1:0] nxt_frac;
    logic [FRAC_WIDTH-1:0] acc_sum;
    logic                  acc_carry;
`endif

    // A same-cycle load wins over the pending value so sync can adopt div_i directly.
    always_comb begin
        tick_c   = en_i && !sync_i && (cnt_q == '0);
        reload   = tick_c || sync_i;
        nxt_div  = div_q;
        if (div_load_i) begin
            nxt_div = div_i;
        end else if (pend_vld_q) begin
            nxt_div = pend_div_q;
        end
        nxt_base = (nxt_div == '0) ? '0 : nxt_div - DIV_WIDTH'(1);
        stretch  = '0;
`ifdef UART_BAUD_FRAC_EN
        nxt_frac = frac_q;
        if (div_load_i) begin
            nxt_frac = frac_i;
        end else if (pend_vld_q) begin
            nxt_frac = pend_frac_q;
        end
        {acc_carry, acc_sum} = ACC_W'(acc_q) + ACC_W'(nxt_frac);
        stretch  = DIV_WIDTH'(acc_carry);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q      <= RST_DIV;
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= RST_CNT;
`ifdef UART_BAUD_FRAC_EN
            frac_q      <= '0;
            pend_frac_q <= '0;
            acc_q       <= '0;
`endif
        end else begin
            if (reload) begin
                div_q      <= nxt_div;
                pend_vld_q <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
                frac_q     <= nxt_frac;
`endif
            end else if (div_load_i) begin
                pend_div_q <= div_i;
                pend_vld_q <= 1'b1;
`ifdef UART_BAUD_FRAC_EN
                pend_frac_q <= frac_i;
`endif
            end

            if (sync_i) begin
                cnt_q <= nxt_base;
`ifdef UART_BAUD_FRAC_EN
                acc_q <= '0;
`endif
            end else if (tick_c) begin
                cnt_q <= nxt_base + stretch;
`ifdef UART_BAUD_FRAC_EN
                acc_q <= acc_sum;
`endif
            end else if (en_i) begin
                cnt_q <= cnt_q - DIV_WIDTH'(1);
            end
        end
    end

    assign div_o = div_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: oversample, bit-centre and bit-boundary ticks from a programmable divisor.
// Optional fractional divisor enabled by defining UART_BAUD_FRAC_EN (adds the frac_i port).
module uart_baud_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLK_RATE  = 100000000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned OVSAMP    = OVSAMP_DEFAULT,
    parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 sync_i,
    input  logic                 div_load_i,
    input  logic [DIV_WIDTH-1:0] div_i,
`ifdef UART_BAUD_FRAC_EN
    input  logic [FRAC_WIDTH-1:0] frac_i,
`endif
    output logic [DIV_WIDTH-1:0] div_o,
    output logic                 ovs_tick_o,
    output logic                 mid_tick_o,
    output logic                 bit_tick_o
);

    localparam int unsigned          PH_W    = $clog2(OVSAMP);
    localparam logic [PH_W-1:0]      MID_PH  = PH_W'(OVSAMP / 2 - 1);
    localparam logic [PH_W-1:0]      LAST_PH = PH_W'(OVSAMP - 1);
    localparam logic [DIV_WIDTH-1:0] RST_DIV =
        DIV_WIDTH'(bddiv(CLK_RATE, BAUD_RATE, OVSAMP));

    logic            tick_c;
    logic [PH_W-1:0] phase_q;

    uart_baud_prescaler #(
        .DIV_WIDTH (DIV_WIDTH),
        .RST_DIV   (RST_DIV)
    ) u_prescaler (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .sync_i     (sync_i),
        .div_load_i (div_load_i),
        .div_i      (div_i),
`ifdef UART_BAUD_FRAC_EN
        .frac_i     (frac_i),
`endif
        .div_o      (div_o),
        .tick_c     (tick_c)
    );

    // Ticks decode the phase before it advances, so the first tick after sync is phase 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q    <= '0;
            ovs_tick_o <= 1'b0;
            mid_tick_o <= 1'b0;
            bit_tick_o <= 1'b0;
        end else begin
            ovs_tick_o <= tick_c;
            mid_tick_o <= tick_c && (phase_q == MID_PH);
            bit_tick_o <= tick_c && (phase_q == LAST_PH);
            if (sync_i) begin
                phase_q <= '0;
            end else if (tick_c) begin
                phase_q <= (phase_q == LAST_PH) ? '0 : phase_q + PH_W'(1);
            end
        end
    end

endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 SHALL have parameter CLK_RATE, default 100000000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, reset baud rate.
REQ-003 SHALL have parameter OVSAMP, default 8, oversampling ticks per bit (even, >= 4).
REQ-004 SHALL have parameter DIV_WIDTH, default 16, divisor register width.
REQ-005 SHALL have port clk_i, input, 1, system clock; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port en_i, input, 1, counting enable.
REQ-008 SHALL have port sync_i, input, 1, phase restart (RX start-bit alignment).
REQ-009 SHALL have port div_load_i, input, 1, one-cycle strobe to load div_i.
REQ-010 SHALL have port div_i, input, DIV_WIDTH, new divisor in clock cycles per ovs tick.
REQ-011 SHALL have port div_o, output, DIV_WIDTH, active divisor.
REQ-012 SHALL have port ovs_tick_o, output, 1, oversample tick.
REQ-013 SHALL have port mid_tick_o, output, 1, bit-centre sample tick.
REQ-014 SHALL have port bit_tick_o, output, 1, bit-boundary tick.

Function
REQ-015 SHALL count down cnt from div-1 to 0, then assert ovs_tick_o for exactly one cycle and reload div-1; period = div cycles.
REQ-016 SHALL treat div = 0 as 1 (ovs_tick_o every enabled cycle).
REQ-017 SHALL advance phase counter 0..OVSAMP-1 (wrap to 0) on each ovs tick.
REQ-018 SHALL assert bit_tick_o with ovs_tick_o when phase = OVSAMP-1; mid_tick_o with ovs_tick_o when phase = OVSAMP/2-1.
REQ-019 SHALL register all tick outputs; with en_i high from the first cycle after reset release, first ovs_tick_o occurs div cycles later.
REQ-020 SHALL hold cnt and phase and emit no ticks while en_i is low; counting resumes from held values.
REQ-021 SHALL latch div_i into a pending register on div_load_i and apply it at the next reload or sync; the running period is never truncated.
REQ-022 SHALL on sync_i set cnt to div-1 and phase to 0, suppress any tick that cycle, and act regardless of en_i.
REQ-023 SHALL on simultaneous sync_i and div_load_i use the new div_i for the sync reload.
REQ-024 SHALL present the currently applied divisor on div_o.

Reset
REQ-025 SHALL on rst_i set div to bddiv(CLK_RATE, BAUD_RATE) truncated to DIV_WIDTH, cnt to div-1, phase to 0, pending load cleared.
REQ-026 SHALL drive all tick outputs 0 during reset and in the following cycle; rst_i overrides sync_i, div_load_i and en_i.

Configuration
REQ-027 SHALL with UART_BAUD_FRAC_EN defined add input frac_i (4 bits, loaded with div_i) and a 4-bit accumulator adding frac each ovs period; carry-out lengthens that period by one cycle.
REQ-028 SHALL clear the accumulator on reset and sync_i.
REQ-029 SHALL without UART_BAUD_FRAC_EN have no frac_i port and integer periods only.

Structure
REQ-030 SHALL place OVSAMP default, bddiv function and typedef div_t (DIV_WIDTH vector) in package baud_pkg.
REQ-031 SHALL implement cnt/reload/fraction logic in sub-module uart_baud_prescaler; phase and tick decode in uart_baud_gen.

Verification
REQ-032 SHALL cover reset default: CLK_RATE=100000000, BAUD_RATE=115200 -> div_o = 108, ovs_tick period 108 cycles.
REQ-033 SHALL cover load div_i=4, OVSAMP=8 -> ovs_tick every 4 cycles, mid_tick every 32 at phase 3, bit_tick every 32 at phase 7.
REQ-034 SHALL cover div_i=0 -> ovs_tick every cycle; bit_tick every 8 cycles.
REQ-035 SHALL cover div_load_i (div 4 -> 10) at cnt=2 -> current period completes at 4 cycles, next period 10.
REQ-036 SHALL cover sync_i at phase 5 -> no tick that cycle, next ovs_tick div cycles later with phase 0, mid_tick after 4 ovs ticks.
REQ-037 SHALL cover UART_BAUD_FRAC_EN, div=4, frac=8 -> periods alternate 4,5; en_i low 10 cycles mid-period -> no ticks, period resumes.
